// File: rtl/mac_array.sv
// mac_array: multi-lane signed multiply-accumulate engine with requantised output.
// One shared activation stream feeds LANES weight lanes. Each pass computes
// bias + sum(a*b) over 'len' beats. The result is then rounded, shifted and
// saturated to OUT_W bits.
//
// Handshakes: a beat transfers on a rising clk edge when in_valid & in_ready.
// A result transfers when out_valid & out_ready. in_ready never depends on
// in_valid, and out_valid never depends on out_ready. Held data must stay
// stable while valid is high and ready is low.
module mac_array #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 16,
    parameter int SH_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic [SH_W-1:0]          shift,
    input  logic [LANES*DATA_W-1:0]  bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        a,
    input  logic [LANES*DATA_W-1:0]  b,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [LANES-1:0]         out_ovf,
    output logic [1:0]               state_dbg
);

    if (ACC_W < 2*DATA_W + LEN_W) begin : g_acc_too_narrow
        $error("mac_array: ACC_W must be >= 2*DATA_W+LEN_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

    localparam int PW = 2*DATA_W;
    // Saturation bounds in the widened requant domain; OMIN is -OMAX-1.
    localparam logic signed [ACC_W:0] OMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OMIN = ~OMAX;

    state_t                  state, state_nx;
    logic [LEN_W-1:0]        len_r, count;
    logic [SH_W-1:0]         shift_r;
    logic                    pend;
    logic                    beat, last_beat, load_out;
    logic signed [PW-1:0]    prod     [LANES];
    logic signed [PW-1:0]    mul      [LANES];
    logic signed [ACC_W-1:0] acc      [LANES];
    logic signed [ACC_W-1:0] acc_next [LANES];
    logic [LANES*OUT_W-1:0]  req_data;
    logic [LANES-1:0]        req_ovf;

    // Round half up, arithmetic shift, then clamp. The result is {ovf, data}.
    // One extra bit keeps the rounding add from wrapping.
    function automatic logic [OUT_W:0] requant(input logic signed [ACC_W-1:0] v,
                                               input logic [SH_W-1:0] sh);
        logic signed [ACC_W:0] x;
        logic signed [ACC_W:0] r;
        x = {v[ACC_W-1], v};
        if (sh != '0) x = x + ((ACC_W+1)'(1) << (sh - SH_W'(1)));
        r = x >>> sh;
        if (r > OMAX)      requant = {1'b1, OMAX[OUT_W-1:0]};
        else if (r < OMIN) requant = {1'b1, OMIN[OUT_W-1:0]};
        else               requant = {1'b0, r[OUT_W-1:0]};
    endfunction

    assign beat      = in_valid & in_ready;
    assign last_beat = beat && ((count + LEN_W'(1)) == len_r);
    // A zero-length pass has no product in flight, so it skips DRAIN.
    assign load_out  = (state == S_DRAIN) || (state == S_ACCUM && len_r == '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: a pass moves IDLE -> ACCUM -> DRAIN -> OUT -> IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ACCUM;
            S_ACCUM: begin
                if (len_r == '0)    state_nx = S_OUT;
                else if (last_beat) state_nx = S_DRAIN;
            end
            S_DRAIN: state_nx = S_OUT;
            S_OUT:   if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        in_ready  = (state == S_ACCUM) && (count < len_r);
        busy      = (state != S_IDLE);
        out_valid = (state == S_OUT);
        state_dbg = state;
    end

    // Lane arithmetic: full-width products, accumulate of the pending product, requant.
    always_comb begin
        req_data = '0;
        req_ovf  = '0;
        for (int i = 0; i < LANES; i++) begin
            mul[i] = PW'($signed(a)) * PW'($signed(b[i*DATA_W +: DATA_W]));
            acc_next[i] = acc[i] + (pend ? {{(ACC_W-PW){prod[i][PW-1]}}, prod[i]} : '0);
            {req_ovf[i], req_data[i*OUT_W +: OUT_W]} = requant(acc_next[i], shift_r);
        end
    end

    // Datapath registers. The product register is one stage ahead of the accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r    <= '0;
            shift_r  <= '0;
            count    <= '0;
            pend     <= 1'b0;
            out_data <= '0;
            out_ovf  <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod[i] <= '0;
                acc[i]  <= '0;
            end
        end else begin
            pend <= beat;
            if (beat) count <= count + LEN_W'(1);
            for (int i = 0; i < LANES; i++) begin
                if (beat) prod[i] <= mul[i];
                if (state == S_IDLE && start)
                    acc[i] <= {{(ACC_W-DATA_W){bias[i*DATA_W+DATA_W-1]}}, bias[i*DATA_W +: DATA_W]};
                else
                    acc[i] <= acc_next[i];
            end
            if (state == S_IDLE && start) begin
                len_r   <= len;
                shift_r <= shift;
                count   <= '0;
            end
            if (load_out) begin
                out_data <= req_data;
                out_ovf  <= req_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: directed and randomized passes through mac_array.
// Results are compared with an arithmetic reference model.
module tb_mac_array;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = 40;
    localparam int OUT_W  = 16;
    localparam int SH_W   = 5;

    logic                     clk, reset, start, in_valid, in_ready, busy, out_valid, out_ready;
    logic [LEN_W-1:0]         len_i;
    logic [SH_W-1:0]          shift_i;
    logic [LANES*DATA_W-1:0]  bias, b;
    logic [DATA_W-1:0]        a;
    logic [LANES*OUT_W-1:0]   out_data;
    logic [LANES-1:0]         out_ovf;
    logic [1:0]               state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard: expected result words and saturation flags, one entry per pass.
    logic [LANES*OUT_W-1:0] exp_q[$];
    logic [LANES-1:0]       ovf_q[$];

    // Stimulus for the current pass.
    logic signed [DATA_W-1:0] a_arr    [256];
    logic signed [DATA_W-1:0] b_arr    [256][LANES];
    logic signed [DATA_W-1:0] bias_arr [LANES];

    mac_array #(.DATA_W(DATA_W), .LANES(LANES), .LEN_W(LEN_W), .ACC_W(ACC_W),
                .OUT_W(OUT_W), .SH_W(SH_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len_i), .shift(shift_i),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .state_dbg(state_dbg)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: exact sum, then round-half-up division by 2**sh, then clamp.
    task automatic model_push(input int n, input int sh);
        logic [LANES*OUT_W-1:0] e;
        logic [LANES-1:0]       o;
        longint s, r, hi, lo;
        hi = (longint'(1) <<< (OUT_W-1)) - 1;
        lo = -hi - 1;
        e = '0;
        o = '0;
        for (int l = 0; l < LANES; l++) begin
            s = longint'(bias_arr[l]);
            for (int k = 0; k < n; k++) s += longint'(a_arr[k]) * longint'(b_arr[k][l]);
            r = (sh == 0) ? s : ((s + (longint'(1) <<< (sh-1))) >>> sh);
            if (r > hi)      begin r = hi; o[l] = 1'b1; end
            else if (r < lo) begin r = lo; o[l] = 1'b1; end
            e[l*OUT_W +: OUT_W] = r[OUT_W-1:0];
        end
        exp_q.push_back(e);
        ovf_q.push_back(o);
    endtask

    task automatic drive_beat(input int idx);
        a = a_arr[idx % 256];
        for (int l = 0; l < LANES; l++) b[l*DATA_W +: DATA_W] = b_arr[idx % 256][l];
    endtask

    task automatic load_start(input int n, input int sh);
        @(negedge clk);
        start   = 1'b1;
        len_i   = LEN_W'(n);
        shift_i = SH_W'(sh);
        for (int l = 0; l < LANES; l++) bias[l*DATA_W +: DATA_W] = bias_arr[l];
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full pass: start, feed beats at vprob% density, check, stall, handshake.
    task automatic run_pass(input int n, input int sh, input int vprob, input int stall);
        int cyc, idx, lat;
        logic [LANES*OUT_W-1:0] held, e;
        logic [LANES-1:0] eo;
        model_push(n, sh);
        load_start(n, sh);
        cyc = 1;
        idx = 0;
        lat = -1;
        while (cyc < 1000 && lat < 0) begin
            if (out_valid) lat = cyc;
            else begin
                in_valid = ($urandom_range(99) < vprob);
                drive_beat(idx);
                if (in_valid && in_ready) idx++;
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = (stall > 0);
        check("result_seen", 64'(out_valid), 64'd1);
        check("beats_taken", 64'(idx), 64'(n));
        if (vprob == 100) check("out_latency", 64'(lat), 64'(n + 2));
        e  = exp_q.pop_front();
        eo = ovf_q.pop_front();
        check("out_data", out_data, e);
        check("out_ovf", 64'(out_ovf), 64'(eo));
        held = out_data;
        for (int s = 0; s < stall; s++) begin
            start = 1'b1;
            @(negedge clk);
            check("stall_data_stable", out_data, held);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_busy", 64'(busy), 64'd1);
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after_busy", 64'(busy), 64'd0);
        check("after_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) begin
            a_arr[k] = DATA_W'($urandom);
            for (int l = 0; l < LANES; l++) b_arr[k][l] = DATA_W'($urandom);
        end
        for (int l = 0; l < LANES; l++) bias_arr[l] = DATA_W'($urandom);
    endtask

    task automatic fill_const(input int n, input int av, input int bv, input int bs);
        for (int k = 0; k < n; k++) begin
            a_arr[k] = DATA_W'(av);
            for (int l = 0; l < LANES; l++) b_arr[k][l] = DATA_W'(bv);
        end
        for (int l = 0; l < LANES; l++) bias_arr[l] = DATA_W'(bs);
    endtask

    initial begin
        int beats, cyc;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        len_i = '0; shift_i = '0; bias = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_out_ovf", 64'(out_ovf), 64'd0);
        reset = 1'b0;

        // Ramp activations against weights {1,-1,2,0}: 325, -325, 650, 0.
        for (int k = 0; k < 25; k++) begin
            a_arr[k] = DATA_W'(k + 1);
            b_arr[k][0] = 16'sd1; b_arr[k][1] = -16'sd1; b_arr[k][2] = 16'sd2; b_arr[k][3] = 16'sd0;
        end
        for (int l = 0; l < LANES; l++) bias_arr[l] = '0;
        run_pass(25, 0, 100, 0);
        // Same sums with sparse input, then a stalled result with start and in_valid spam.
        run_pass(25, 0, 50, 5);

        // Saturation in both directions.
        fill_const(4, 32767, 32767, 0);
        run_pass(4, 0, 100, 0);
        fill_const(4, -32768, 32767, 0);
        run_pass(4, 0, 100, 0);

        // Rounding: 5>>1 -> 3, -5>>1 -> -2, 6>>2 -> 2.
        fill_const(1, 5, 1, 0);  run_pass(1, 1, 100, 0);
        fill_const(1, -5, 1, 0); run_pass(1, 1, 100, 0);
        fill_const(1, 6, 1, 0);  run_pass(1, 2, 100, 0);

        // Zero-length pass returns the bias.
        fill_const(1, 3, 3, 7);
        run_pass(0, 0, 100, 0);

        // Reset in the middle of a pass abandons it.
        fill_random(25);
        load_start(25, 0);
        beats = 0;
        cyc = 0;
        while (beats < 10 && cyc < 100) begin
            in_valid = 1'b1;
            drive_beat(beats);
            if (in_ready) beats++;
            @(negedge clk);
            cyc++;
        end
        check("midpass_beats", 64'(beats), 64'd10);
        reset = 1'b1;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("postreset_out_valid", 64'(out_valid), 64'd0);
        fill_const(3, 2, 2, 1);
        run_pass(3, 0, 100, 0);

        // Randomized passes, including the longest legal length.
        for (int p = 0; p < 8; p++) begin
            int n;
            n = $urandom_range(20, 1);
            fill_random(n);
            run_pass(n, $urandom_range(24, 0), $urandom_range(100, 40), $urandom_range(3, 0));
        end
        fill_random(255);
        run_pass(255, $urandom_range(31, 0), 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
